// File: rtl/stream_demux_2_pkg.sv
//------------------------------------------------------------------------------
// Module   : stream_demux_2_pkg
// Brief    : Shared types and constants for the registered 1:2 stream demux.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package stream_demux_2_pkg;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/stream_demux_2_if.sv
//------------------------------------------------------------------------------
// Module   : stream_demux_2_if
// Brief    : Input stream and two output streams of stream_demux_2.
//            Pop counters exist only when STREAM_DEMUX_2_COUNT_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface stream_demux_2_if
    import stream_demux_2_pkg::*;
#(
    parameter int WIDTH = 4
);

    logic [WIDTH-1:0] i_data;
    logic             i_sel;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_data_0;
    logic             o_valid_0;
    logic             i_ready_0;
    logic [WIDTH-1:0] o_data_1;
    logic             o_valid_1;
    logic             i_ready_1;

`ifdef STREAM_DEMUX_2_COUNT_EN
    logic [CNT_W-1:0] o_count_0;
    logic [CNT_W-1:0] o_count_1;

    modport slave (
        input  i_data, i_sel, i_valid, i_ready_0, i_ready_1,
        output o_ready, o_data_0, o_valid_0, o_data_1, o_valid_1,
        output o_count_0, o_count_1
    );

    modport master (
        output i_data, i_sel, i_valid, i_ready_0, i_ready_1,
        input  o_ready, o_data_0, o_valid_0, o_data_1, o_valid_1,
        input  o_count_0, o_count_1
    );
`else
    modport slave (
        input  i_data, i_sel, i_valid, i_ready_0, i_ready_1,
        output o_ready, o_data_0, o_valid_0, o_data_1, o_valid_1
    );

    modport master (
        output i_data, i_sel, i_valid, i_ready_0, i_ready_1,
        input  o_ready, o_data_0, o_valid_0, o_data_1, o_valid_1
    );
`endif

endinterface

`default_nettype wire

// File: rtl/stream_demux_2_buf.sv
//------------------------------------------------------------------------------
// Module   : stream_buf_2
// Brief    : Two-entry registered FIFO with head/valid driven from flops.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stream_buf_2
    import stream_demux_2_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_valid,
    output buf_state_t       o_state
);

    localparam logic [1:0] c_st_empty = EMPTY;
    localparam logic [1:0] c_st_one   = ONE;
    localparam logic [1:0] c_st_two   = TWO;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_valid;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_empty: begin
                if (i_push) w_state_nxt = c_st_one;
            end
            c_st_one: begin
                if (i_push && !i_pop)      w_state_nxt = c_st_two;
                else if (!i_push && i_pop) w_state_nxt = c_st_empty;
            end
            c_st_two: begin
                if (i_pop) w_state_nxt = c_st_one;
            end
            default: w_state_nxt = c_st_empty;
        endcase
    end

    // Valid is registered from the next state so it leaves a flop directly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_st_empty;
            r_valid <= 1'b0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt != c_st_empty);
            case (r_state)
                c_st_empty: begin
                    if (i_push) r_head <= i_push_data;
                end
                c_st_one: begin
                    if (i_push && i_pop) r_head <= i_push_data;
                    else if (i_push)     r_tail <= i_push_data;
                end
                c_st_two: begin
                    if (i_pop) r_head <= r_tail;
                end
                default: ;
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_valid = r_valid;
    assign o_state = buf_state_t'(r_state);

endmodule

`default_nettype wire

// File: rtl/stream_demux_2.sv
//------------------------------------------------------------------------------
// Module   : stream_demux_2
// Brief    : Registered 1:2 stream demux, one 2-entry buffer per output.
//            Optional pop counters enabled by STREAM_DEMUX_2_COUNT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stream_demux_2
    import stream_demux_2_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    stream_demux_2_if.slave bus
);

    buf_state_t w_state_0;
    buf_state_t w_state_1;
    logic       w_ready;
    logic       w_push_0;
    logic       w_push_1;
    logic       w_pop_0;
    logic       w_pop_1;
    logic       w_valid_0;
    logic       w_valid_1;

    // Ready depends only on the selected buffer, never on consumer ready.
    assign w_ready  = bus.i_sel ? (w_state_1 != TWO) : (w_state_0 != TWO);
    assign w_push_0 = bus.i_valid && w_ready && !bus.i_sel;
    assign w_push_1 = bus.i_valid && w_ready &&  bus.i_sel;
    assign w_pop_0  = w_valid_0 && bus.i_ready_0;
    assign w_pop_1  = w_valid_1 && bus.i_ready_1;

    assign bus.o_ready   = w_ready;
    assign bus.o_valid_0 = w_valid_0;
    assign bus.o_valid_1 = w_valid_1;

    stream_buf_2 #(.WIDTH(WIDTH)) u_buf_0 (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_push_0),
        .i_push_data (bus.i_data),
        .i_pop       (w_pop_0),
        .o_head      (bus.o_data_0),
        .o_valid     (w_valid_0),
        .o_state     (w_state_0)
    );

    stream_buf_2 #(.WIDTH(WIDTH)) u_buf_1 (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_push_1),
        .i_push_data (bus.i_data),
        .i_pop       (w_pop_1),
        .o_head      (bus.o_data_1),
        .o_valid     (w_valid_1),
        .o_state     (w_state_1)
    );

`ifdef STREAM_DEMUX_2_COUNT_EN
    logic [CNT_W-1:0] r_count_0;
    logic [CNT_W-1:0] r_count_1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count_0 <= '0;
            r_count_1 <= '0;
        end else begin
            if (w_pop_0) r_count_0 <= r_count_0 + CNT_W'(1);
            if (w_pop_1) r_count_1 <= r_count_1 + CNT_W'(1);
        end
    end

    assign bus.o_count_0 = r_count_0;
    assign bus.o_count_1 = r_count_1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_demux_2.sv
//------------------------------------------------------------------------------
// Module   : tb_stream_demux_2
// Brief    : Self-checking bench for stream_demux_2 against a queue model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_stream_demux_2;
    import stream_demux_2_pkg::*;

    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_demux_2_if #(.WIDTH(WIDTH)) bus ();

    stream_demux_2 #(.WIDTH(WIDTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference: one plain queue per output plus wrap-around pop counts.
    logic [WIDTH-1:0] mq0[$];
    logic [WIDTH-1:0] mq1[$];
    logic [15:0]      mcnt0 = '0;
    logic [15:0]      mcnt1 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mq0.delete();
                mq1.delete();
                mcnt0 = '0;
                mcnt1 = '0;
            end else begin
                automatic bit p0 = (mq0.size() > 0) && bus.i_ready_0;
                automatic bit p1 = (mq1.size() > 0) && bus.i_ready_1;
                automatic bit room = bus.i_sel ? (mq1.size() != 2) : (mq0.size() != 2);
                automatic bit push = bus.i_valid && room;
                if (p0) begin void'(mq0.pop_front()); mcnt0++; end
                if (p1) begin void'(mq1.pop_front()); mcnt1++; end
                if (push) begin
                    if (bus.i_sel) mq1.push_back(bus.i_data);
                    else           mq0.push_back(bus.i_data);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("m_valid_0", 32'(bus.o_valid_0), 32'(mq0.size() > 0));
                chk("m_valid_1", 32'(bus.o_valid_1), 32'(mq1.size() > 0));
                if (mq0.size() > 0) chk("m_data_0", 32'(bus.o_data_0), 32'(mq0[0]));
                if (mq1.size() > 0) chk("m_data_1", 32'(bus.o_data_1), 32'(mq1[0]));
                chk("m_ready", 32'(bus.o_ready),
                    32'(bus.i_sel ? (mq1.size() != 2) : (mq0.size() != 2)));
`ifdef STREAM_DEMUX_2_COUNT_EN
                chk("m_count_0", 32'(bus.o_count_0), 32'(mcnt0));
                chk("m_count_1", 32'(bus.o_count_1), 32'(mcnt1));
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic s, input logic [WIDTH-1:0] d,
                       input logic r0, input logic r1);
        bus.i_valid   = v;
        bus.i_sel     = s;
        bus.i_data    = d;
        bus.i_ready_0 = r0;
        bus.i_ready_1 = r1;
    endtask

    initial begin
        drv(1'b1, 1'b0, 4'h5, 1'b1, 1'b1);

        // Reset held two cycles with valid asserted.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        drv(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        #1;
        chk("rst_valid_0", 32'(bus.o_valid_0), 32'd0);
        chk("rst_valid_1", 32'(bus.o_valid_1), 32'd0);
        chk("rst_data_0",  32'(bus.o_data_0),  32'h0);
        chk("rst_data_1",  32'(bus.o_data_1),  32'h0);
        chk("rst_ready",   32'(bus.o_ready),   32'd1);
        chk_en = 1'b1;

        // Basic routing.
        drv(1'b1, 1'b0, 4'h3, 1'b1, 1'b1);
        step();
        chk("route_data_0", 32'(bus.o_data_0), 32'h3);
        chk("route_valid_0", 32'(bus.o_valid_0), 32'd1);
        drv(1'b1, 1'b1, 4'h5, 1'b1, 1'b1);
        step();
        chk("route_valid_0_drop", 32'(bus.o_valid_0), 32'd0);
        chk("route_data_1", 32'(bus.o_data_1), 32'h5);
        chk("route_valid_1", 32'(bus.o_valid_1), 32'd1);
        drv(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        step();
        chk("route_valid_1_drop", 32'(bus.o_valid_1), 32'd0);

        // Backpressure on output 0.
        drv(1'b1, 1'b0, 4'hA, 1'b0, 1'b1);
        step();
        drv(1'b1, 1'b0, 4'hB, 1'b0, 1'b1);
        step();
        drv(1'b1, 1'b0, 4'hC, 1'b0, 1'b1);
        #1;
        chk("full_ready_sel0", 32'(bus.o_ready), 32'd0);
        drv(1'b0, 1'b1, 4'hC, 1'b0, 1'b1);
        #1;
        chk("full_ready_sel1", 32'(bus.o_ready), 32'd1);
        drv(1'b1, 1'b0, 4'hC, 1'b0, 1'b1);
        step();
        chk("full_hold_A", 32'(bus.o_data_0), 32'hA);
        drv(1'b1, 1'b0, 4'hC, 1'b1, 1'b1);
        step();
        chk("drain_B", 32'(bus.o_data_0), 32'hB);
        step();
        chk("drain_C", 32'(bus.o_data_0), 32'hC);
        drv(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        step();
        chk("drain_empty", 32'(bus.o_valid_0), 32'd0);

        // Simultaneous push and pop while holding one word.
        drv(1'b1, 1'b0, 4'h1, 1'b0, 1'b1);
        step();
        drv(1'b1, 1'b0, 4'h2, 1'b1, 1'b1);
        step();
        chk("pp_data_0", 32'(bus.o_data_0), 32'h2);
        chk("pp_valid_0", 32'(bus.o_valid_0), 32'd1);
        chk("pp_state_one", 32'(dut.w_state_0), 32'(ONE));
        drv(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        step();

        // Isolation: output 1 stalled full while output 0 streams.
        drv(1'b1, 1'b1, 4'h7, 1'b1, 1'b0);
        step();
        drv(1'b1, 1'b1, 4'h8, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 16; i++) begin
            drv(1'b1, 1'b0, 4'(i), 1'b1, 1'b0);
            step();
            chk("iso_data_0", 32'(bus.o_data_0), 32'(i));
            chk("iso_data_1", 32'(bus.o_data_1), 32'h7);
        end
        drv(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        step();

        // Reset mid-stream with both buffers full.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 1'b1, 4'(i + 9), 1'b1, 1'b1);
            step();
        end
        drv(1'b0, 1'b1, 4'h0, 1'b1, 1'b1);
        step();
`ifdef STREAM_DEMUX_2_COUNT_EN
        chk("cnt_1_three", 32'(bus.o_count_1), 32'd3);
`endif
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 1'(i % 2), 4'(i + 4), 1'b0, 1'b0);
            step();
        end
        chk("mid_full_0", 32'(dut.w_state_0), 32'(TWO));
        chk("mid_full_1", 32'(dut.w_state_1), 32'(TWO));
        rst = 1'b1;
        step();
        rst = 1'b0;
        drv(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        chk("mid_rst_valid_0", 32'(bus.o_valid_0), 32'd0);
        chk("mid_rst_valid_1", 32'(bus.o_valid_1), 32'd0);
`ifdef STREAM_DEMUX_2_COUNT_EN
        chk("mid_rst_cnt_0", 32'(bus.o_count_0), 32'd0);
        chk("mid_rst_cnt_1", 32'(bus.o_count_1), 32'd0);
`endif

        // Randomized traffic, occasional reset.
        for (int i = 0; i < 3000; i++) begin
            drv(1'(($urandom % 4) != 0), 1'($urandom % 2), 4'($urandom),
                1'(($urandom % 10) < 7), 1'(($urandom % 2)));
            rst = 1'(($urandom % 500) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
